// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg
//   Shared types and default widths for the layer sequencer slice.
//   Contents:
//     seq_state_e     chain sequencer states
//     layer_desc_t    one descriptor entry: token / weight / result base
//     count_is_legal  range check applied to a requested layer count
//   Optional feature macro used by the slice: LAYER_TIMEOUT_EN (per-layer watchdog).

package layer_seq_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 10;
  localparam int unsigned DEF_MAX_LAYERS     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  // Descriptor fields are fixed at the default BRAM address width; the
  // sequencer refuses to elaborate with any other ADDR_WIDTH.
  localparam int unsigned DESC_ADDR_W = DEF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KICK   = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] tok_base;
    logic [DESC_ADDR_W-1:0] wgt_base;
    logic [DESC_ADDR_W-1:0] res_base;
  } layer_desc_t;

  function automatic logic count_is_legal(input int unsigned n,
                                          input int unsigned max_layers);
    return (n != 0) && (n <= max_layers);
  endfunction

endpackage

// File: rtl/layer_desc_table.sv
// layer_desc_table
//   Host-written descriptor register file, MAX_LAYERS entries of layer_desc_t.
//   One synchronous write port, one combinational read port.
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-low clear of every entry
//     wr_en_i    write strobe (already qualified by the caller)
//     wr_idx_i   entry to write
//     wr_desc_i  descriptor value to write
//     rd_idx_i   entry to read
//     rd_desc_o  descriptor at rd_idx_i

module layer_desc_table
  import layer_seq_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = DEF_MAX_LAYERS,
  parameter int unsigned IDX_W      = $clog2(MAX_LAYERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  layer_desc_t       wr_desc_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output layer_desc_t       rd_desc_o
);

  layer_desc_t mem_q [MAX_LAYERS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_desc_i;
    end
  end

  // MAX_LAYERS is a power of two, so every index value addresses a real entry.
  assign rd_desc_o = mem_q[rd_idx_i];

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Runs a programmed chain of up to MAX_LAYERS layers back-to-back on the
//   single per-layer controller: presents each layer's bases, pulses
//   lyr_start, waits for lyr_done, advances, and pulses done at the end.
//   Optional feature macro: LAYER_TIMEOUT_EN adds a per-layer watchdog of
//   TIMEOUT_CYCLES cycles in WAIT; without it WAIT waits indefinitely.
//   Ports:
//     clk, rst                 clock / synchronous active-low reset
//     cfg_wr_en, cfg_wr_idx,   descriptor write (accepted only in IDLE)
//     cfg_tok/wgt/res_base
//     num_layers               chain length, latched at run_start (1..MAX_LAYERS)
//     run_start, abort         chain control
//     lyr_start/busy/done      per-layer controller handshake
//     tok/wgt/res_base         current layer bases, registered
//     cur_layer                layer in progress
//     busy, done, error        chain status (error is sticky until a legal start)
//
// state  | meaning
// IDLE   | no chain; descriptor writes accepted, waits for run_start
// LOAD   | register table[cur_layer] onto the bases; stall while lyr_busy
// KICK   | lyr_start high for exactly this cycle
// WAIT   | wait for lyr_done (watchdog counts here when enabled)
// NEXT   | last layer -> FINISH, otherwise advance cur_layer -> LOAD
// FINISH | done high for this cycle; busy drops on exit

module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_LAYERS     = DEF_MAX_LAYERS,
  parameter int unsigned IDX_W          = $clog2(MAX_LAYERS),
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_en,
  input  logic [IDX_W-1:0]      cfg_wr_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_tok_base,
  input  logic [ADDR_WIDTH-1:0] cfg_wgt_base,
  input  logic [ADDR_WIDTH-1:0] cfg_res_base,
  input  logic [IDX_W:0]        num_layers,
  input  logic                  run_start,
  input  logic                  abort,
  output logic                  lyr_start,
  input  logic                  lyr_busy,
  input  logic                  lyr_done,
  output logic [ADDR_WIDTH-1:0] tok_base,
  output logic [ADDR_WIDTH-1:0] wgt_base,
  output logic [ADDR_WIDTH-1:0] res_base,
  output logic [IDX_W-1:0]      cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned NUM_W = IDX_W + 1;

  if ((MAX_LAYERS < 2) || ((MAX_LAYERS & (MAX_LAYERS - 1)) != 0) ||
      (IDX_W != $clog2(MAX_LAYERS)) || (ADDR_WIDTH != DESC_ADDR_W) ||
      (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("layer_sequencer: unsupported parameter set");
  end

  seq_state_e            state_q;
  logic [IDX_W-1:0]      cur_q;
  logic [NUM_W-1:0]      num_q;
  logic [ADDR_WIDTH-1:0] tok_q;
  logic [ADDR_WIDTH-1:0] wgt_q;
  logic [ADDR_WIDTH-1:0] res_q;
  logic                  lyr_start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic                  cfg_we;
  layer_desc_t           wr_desc;
  layer_desc_t           rd_desc;
  logic                  start_legal;
  logic                  last_layer;

  // Writes are only honoured while no chain is running; a write in the same
  // cycle as run_start lands before LOAD reads the table.
  assign cfg_we  = cfg_wr_en && (state_q == S_IDLE);
  assign wr_desc = '{tok_base: cfg_tok_base,
                     wgt_base: cfg_wgt_base,
                     res_base: cfg_res_base};

  layer_desc_table #(
    .MAX_LAYERS (MAX_LAYERS),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (cfg_we),
    .wr_idx_i  (cfg_wr_idx),
    .wr_desc_i (wr_desc),
    .rd_idx_i  (cur_q),
    .rd_desc_o (rd_desc)
  );

  assign start_legal = count_is_legal(32'(num_layers), MAX_LAYERS);
  assign last_layer  = ({1'b0, cur_q} == (num_q - NUM_W'(1)));

`ifdef LAYER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wdog_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      num_q       <= '0;
      tok_q       <= '0;
      wgt_q       <= '0;
      res_q       <= '0;
      lyr_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      // Both pulses are single-cycle; they are only re-raised on entry.
      lyr_start_q <= 1'b0;
      done_q      <= 1'b0;

      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run_start && !abort) begin
              if (start_legal) begin
                state_q <= S_LOAD;
                error_q <= 1'b0;
                cur_q   <= '0;
                num_q   <= num_layers;
                busy_q  <= 1'b1;
              end else begin
                error_q <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            tok_q <= rd_desc.tok_base;
            wgt_q <= rd_desc.wgt_base;
            res_q <= rd_desc.res_base;
            if (!lyr_busy) begin
              state_q     <= S_KICK;
              lyr_start_q <= 1'b1;
            end
          end

          S_KICK: begin
            state_q <= S_WAIT;
`ifdef LAYER_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end

          S_WAIT: begin
            if (lyr_done) begin
              state_q <= S_NEXT;
`ifdef LAYER_TIMEOUT_EN
            end else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              // TIMEOUT_CYCLES WAIT cycles elapsed with no lyr_done.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              wdog_q  <= wdog_q + CNT_W'(1);
`endif
            end
          end

          S_NEXT: begin
            if (last_layer) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              cur_q   <= cur_q + IDX_W'(1);
              state_q <= S_LOAD;
            end
          end

          S_FINISH: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lyr_start = lyr_start_q;
  assign tok_base  = tok_q;
  assign wgt_base  = wgt_q;
  assign res_base  = res_q;
  assign cur_layer = cur_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

  localparam int AW = 10;
  localparam int ML = 4;
  localparam int IW = 2;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr_en;
  logic [IW-1:0] cfg_wr_idx;
  logic [AW-1:0] cfg_tok_base, cfg_wgt_base, cfg_res_base;
  logic [IW:0]   num_layers;
  logic          run_start, abort;
  logic          lyr_start, lyr_busy, lyr_done;
  logic [AW-1:0] tok_base, wgt_base, res_base;
  logic [IW-1:0] cur_layer;
  logic          busy, done, error;

  layer_sequencer #(
    .ADDR_WIDTH     (AW),
    .MAX_LAYERS     (ML),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_idx   (cfg_wr_idx),
    .cfg_tok_base (cfg_tok_base),
    .cfg_wgt_base (cfg_wgt_base),
    .cfg_res_base (cfg_res_base),
    .num_layers   (num_layers),
    .run_start    (run_start),
    .abort        (abort),
    .lyr_start    (lyr_start),
    .lyr_busy     (lyr_busy),
    .lyr_done     (lyr_done),
    .tok_base     (tok_base),
    .wgt_base     (wgt_base),
    .res_base     (res_base),
    .cur_layer    (cur_layer),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference descriptor table: what the host has successfully written.
  logic [AW-1:0] m_tok [ML];
  logic [AW-1:0] m_wgt [ML];
  logic [AW-1:0] m_res [ML];

  // Observation log, sampled on the falling edge.
  logic [AW-1:0] q_tok [$];
  logic [AW-1:0] q_wgt [$];
  logic [AW-1:0] q_res [$];
  int            q_cur [$];
  int            q_scyc[$];
  int            done_cnt = 0;
  int            last_done_cyc = 0;

  always @(negedge clk) begin
    if (lyr_start === 1'b1) begin
      q_tok.push_back(tok_base);
      q_wgt.push_back(wgt_base);
      q_res.push_back(res_base);
      q_cur.push_back(int'(cur_layer));
      q_scyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // Layer controller stand-in: answers each lyr_start with a done pulse
  // done_lat cycles later; done_lat == 0 means it never answers.
  int done_lat;
  initial begin
    int pending;
    pending  = 0;
    lyr_done = 1'b0;
    forever begin
      @(negedge clk);
      lyr_done = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) lyr_done = 1'b1;
      end
      if (lyr_start === 1'b1) pending = done_lat;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed cycle %0d required < 50000", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input logic [AW-1:0] t, input logic [AW-1:0] w,
                           input logic [AW-1:0] r, input bit applies);
    cfg_wr_en    = 1'b1;
    cfg_wr_idx   = idx[IW-1:0];
    cfg_tok_base = t;
    cfg_wgt_base = w;
    cfg_res_base = r;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    if (applies) begin
      m_tok[idx] = t;
      m_wgt[idx] = w;
      m_res[idx] = r;
    end
  endtask

  task automatic start_pulse(input int n, input bit coinc, input logic [AW-1:0] t,
                             input logic [AW-1:0] w, input logic [AW-1:0] r, output int rs);
    num_layers = n[IW:0];
    run_start  = 1'b1;
    rs         = cyc;
    if (coinc) begin
      cfg_wr_en    = 1'b1;
      cfg_wr_idx   = '0;
      cfg_tok_base = t;
      cfg_wgt_base = w;
      cfg_res_base = r;
      m_tok[0] = t;
      m_wgt[0] = w;
      m_res[0] = r;
    end
    @(negedge clk);
    run_start = 1'b0;
    cfg_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok, output int end_cyc);
    ok = 1'b0;
    end_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        end_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_chain(input string tag, input int mark, input int dmark, input int n,
                             input int exp_first, input bit ok, input int end_cyc);
    check($sformatf("%s_ended", tag), 32'(ok), 32'd1);
    check($sformatf("%s_starts", tag), q_tok.size() - mark, n);
    for (int i = 0; i < n; i++) begin
      if (mark + i < q_tok.size()) begin
        check($sformatf("%s_tok%0d", tag, i), q_tok[mark+i], m_tok[i]);
        check($sformatf("%s_wgt%0d", tag, i), q_wgt[mark+i], m_wgt[i]);
        check($sformatf("%s_res%0d", tag, i), q_res[mark+i], m_res[i]);
        check($sformatf("%s_cur%0d", tag, i), q_cur[mark+i], i);
      end
    end
    if (q_scyc.size() > mark)
      check($sformatf("%s_first_start_cyc", tag), q_scyc[mark], exp_first);
    check($sformatf("%s_done_pulses", tag), done_cnt - dmark, 1);
    if (done_cnt - dmark == 1)
      check($sformatf("%s_busy_low_after_done", tag), end_cyc, last_done_cyc + 1);
    check($sformatf("%s_error", tag), error, 0);
  endtask

  task automatic run_and_check(input string tag, input int n, input int lat, input bit coinc,
                               input logic [AW-1:0] t, input logic [AW-1:0] w,
                               input logic [AW-1:0] r);
    int mark, dmark, rs, endc;
    bit ok;
    done_lat = lat;
    mark  = q_tok.size();
    dmark = done_cnt;
    start_pulse(n, coinc, t, w, r, rs);
    wait_idle(3000, ok, endc);
    check_chain(tag, mark, dmark, n, rs + 2, ok, endc);
  endtask

  initial begin
    int  mark, dmark, rs, rs2, endc, fall;
    bit  ok;

    done_lat     = 1;
    rst          = 1'b0;
    cfg_wr_en    = 1'b0;
    cfg_wr_idx   = '0;
    cfg_tok_base = '0;
    cfg_wgt_base = '0;
    cfg_res_base = '0;
    num_layers   = '0;
    run_start    = 1'b0;
    abort        = 1'b0;
    lyr_busy     = 1'b0;
    for (int i = 0; i < ML; i++) begin
      m_tok[i] = '0;
      m_wgt[i] = '0;
      m_res[i] = '0;
    end
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_lyr_start", lyr_start, 0);
    check("rst_tok", tok_base, 0);
    check("rst_cur", cur_layer, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed three-layer chain.
    cfg_write(0, 10'h000, 10'h100, 10'h200, 1'b1);
    cfg_write(1, 10'h200, 10'h120, 10'h300, 1'b1);
    cfg_write(2, 10'h300, 10'h140, 10'h020, 1'b1);
    run_and_check("chain3", 3, 40, 1'b0, '0, '0, '0);

    // Stall while the layer controller is still busy.
    done_lat = 5;
    mark  = q_tok.size();
    dmark = done_cnt;
    lyr_busy = 1'b1;
    start_pulse(1, 1'b0, '0, '0, '0, rs);
    repeat (9) @(negedge clk);
    check("stall_no_start", q_tok.size() - mark, 0);
    check("stall_busy", busy, 1);
    fall = cyc;
    lyr_busy = 1'b0;
    wait_idle(500, ok, endc);
    check_chain("stall", mark, dmark, 1, fall + 1, ok, endc);

    // Illegal counts, then a legal run clears the error.
    mark = q_tok.size();
    start_pulse(0, 1'b0, '0, '0, '0, rs);
    check("illegal0_error", error, 1);
    check("illegal0_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("illegal0_no_start", q_tok.size() - mark, 0);
    start_pulse(ML + 1, 1'b0, '0, '0, '0, rs);
    check("illegal5_error", error, 1);
    check("illegal5_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("illegal5_no_start", q_tok.size() - mark, 0);
    run_and_check("after_illegal", 1, 3, 1'b0, '0, '0, '0);

    // abort together with run_start in IDLE: no start.
    mark = q_tok.size();
    abort = 1'b1;
    start_pulse(2, 1'b0, '0, '0, '0, rs);
    abort = 1'b0;
    check("abort_idle_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("abort_idle_no_start", q_tok.size() - mark, 0);

    // abort in WAIT of layer 1 of a four-layer chain.
    for (int e = 0; e < ML; e++)
      cfg_write(e, AW'($urandom), AW'($urandom), AW'($urandom), 1'b1);
    done_lat = 30;
    mark  = q_tok.size();
    dmark = done_cnt;
    start_pulse(4, 1'b0, '0, '0, '0, rs);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (lyr_start === 1'b1 && cur_layer === 2'd1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_layer1", 32'(ok), 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_lyr_start", lyr_start, 0);
    check("abort_error", error, 0);
    repeat (60) @(negedge clk);
    check("abort_starts", q_tok.size() - mark, 2);
    check("abort_no_done", done_cnt - dmark, 0);
    run_and_check("post_abort", 2, 4, 1'b0, '0, '0, '0);

    // cfg write and second run_start while busy are ignored.
    done_lat = 20;
    mark  = q_tok.size();
    dmark = done_cnt;
    start_pulse(3, 1'b0, '0, '0, '0, rs);
    for (int i = 0; i < 50; i++) begin
      if (lyr_start === 1'b1) break;
      @(negedge clk);
    end
    @(negedge clk);
    cfg_write(1, ~m_tok[1], ~m_wgt[1], ~m_res[1], 1'b0);
    start_pulse(1, 1'b0, '0, '0, '0, rs2);
    wait_idle(3000, ok, endc);
    check_chain("busy_ignore", mark, dmark, 3, rs + 2, ok, endc);

    // Reset in KICK: lyr_start drops at the same edge, table cleared.
    done_lat = 10;
    start_pulse(2, 1'b0, '0, '0, '0, rs);
    for (int i = 0; i < 50; i++) begin
      if (lyr_start === 1'b1) break;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst_lyr_start", lyr_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tok", tok_base, 0);
    check("midrst_cur", cur_layer, 0);
    rst = 1'b1;
    for (int i = 0; i < ML; i++) begin
      m_tok[i] = '0;
      m_wgt[i] = '0;
      m_res[i] = '0;
    end
    @(negedge clk);
    run_and_check("post_reset", 2, 3, 1'b0, '0, '0, '0);

    // Randomized chains, with a write to entry 0 landing alongside run_start.
    for (int it = 0; it < 5; it++) begin
      for (int e = 1; e < ML; e++)
        cfg_write(e, AW'($urandom), AW'($urandom), AW'($urandom), 1'b1);
      run_and_check($sformatf("rand%0d", it), int'($urandom_range(1, ML)),
                    int'($urandom_range(1, 12)), 1'b1,
                    AW'($urandom), AW'($urandom), AW'($urandom));
    end

`ifdef LAYER_TIMEOUT_EN
    // Watchdog: the layer never reports done.
    done_lat = 0;
    mark  = q_tok.size();
    dmark = done_cnt;
    start_pulse(2, 1'b0, '0, '0, '0, rs);
    wait_idle(400, ok, endc);
    check("wdog_ended", 32'(ok), 1);
    check("wdog_error", error, 1);
    check("wdog_starts", q_tok.size() - mark, 1);
    check("wdog_no_done", done_cnt - dmark, 0);
    if (q_scyc.size() > mark)
      check("wdog_wait_cycles", endc - q_scyc[mark], TO + 1);
    run_and_check("post_wdog", 1, 2, 1'b0, '0, '0, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Runs a programmed chain of up to MAX_LAYERS linear layers back-to-back on the single layer datapath (token/weight/result BRAMs plus the per-layer controller).
A host-written descriptor table holds token, weight and result base addresses per layer.
The sequencer presents each layer's bases, pulses the per-layer start, waits for that layer's done, advances, and signals completion of the whole chain.
It sits between host control and the per-layer controller start/busy/done handshake.

Parameters:
ADDR_WIDTH, 10, BRAM address width of every base address.
MAX_LAYERS, 4, descriptor table depth; power of two, minimum 2.
IDX_W, $clog2(MAX_LAYERS), layer index width (derived).
TIMEOUT_CYCLES, 4096, per-layer watchdog limit; used only with LAYER_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-low reset.
cfg_wr_en  in  1  descriptor write strobe.
cfg_wr_idx  in  IDX_W  descriptor entry to write.
cfg_tok_base  in  ADDR_WIDTH  token base for that entry.
cfg_wgt_base  in  ADDR_WIDTH  weight base for that entry.
cfg_res_base  in  ADDR_WIDTH  result base for that entry.
num_layers  in  IDX_W+1  layers to run; legal range 1..MAX_LAYERS.
run_start  in  1  start-chain pulse.
abort  in  1  abandon the chain.
lyr_start  out  1  one-cycle start to the layer controller.
lyr_busy  in  1  layer controller busy.
lyr_done  in  1  layer controller done pulse.
tok_base  out  ADDR_WIDTH  current layer token base, registered.
wgt_base  out  ADDR_WIDTH  current layer weight base, registered.
res_base  out  ADDR_WIDTH  current layer result base, registered.
cur_layer  out  IDX_W  index of the layer in progress.
busy  out  1  chain in progress.
done  out  1  one-cycle pulse when the chain completes.
error  out  1  sticky fault flag.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State IDLE. All outputs 0.
  - Descriptor table cleared to 0.
  - Reset mid-chain takes priority over everything and drops lyr_start the same edge.
- States:
  - IDLE:
    - run_start with num_layers in 1..MAX_LAYERS → LOAD; clears error; cur_layer=0; busy=1 next cycle.
    - run_start with an illegal num_layers (0 or >MAX_LAYERS) → error=1, stay IDLE.
  - LOAD: register the table[cur_layer] fields onto tok/wgt/res_base. If lyr_busy=0 → KICK, else remain in LOAD (stall).
  - KICK: lyr_start=1 for exactly this cycle → WAIT. A lyr_done seen in KICK is ignored.
  - WAIT: on lyr_done → NEXT.
  - NEXT:
    - If cur_layer == num_layers-1 → FINISH.
    - Else cur_layer+1 → LOAD.
  - FINISH: done=1 for one cycle, busy=0 next cycle → IDLE.
- Timing:
  - Minimum per layer is LOAD, KICK, WAIT(≥1 cycle), NEXT.
  - Bases are stable from the cycle after LOAD until the next LOAD.
  - First lyr_start comes 2 cycles after run_start is sampled.
- Latched count: num_layers is latched at run_start; later changes are ignored until the next run.
- cfg_wr_en: honoured only in IDLE, ignored while busy. A cfg write coinciding with run_start is applied; the chain uses the new entry.
- run_start while busy: ignored.
- abort:
  - Any non-IDLE state → IDLE next cycle; lyr_start forced 0; no done pulse; busy=0; error unchanged.
  - abort together with run_start in IDLE: abort wins, no start.
- lyr_done outside WAIT: ignored.
- cur_layer does not wrap. A legal num_layers guarantees the last index is MAX_LAYERS-1 at most.

Optional Feature:
LAYER_TIMEOUT_EN
- Defined:
  - Per-layer cycle counter is cleared in KICK and increments in WAIT.
  - Reaching TIMEOUT_CYCLES without lyr_done → error=1, IDLE, no done pulse.
  - Error is cleared on the next legal run_start.
- Undefined: no counter logic; WAIT waits indefinitely.

Decomposition:
- Package layer_seq_pkg:
  - State enum (IDLE, LOAD, KICK, WAIT, NEXT, FINISH).
  - Packed struct layer_desc_t {tok_base, wgt_base, res_base}.
  - Default widths.
- Sub-module layer_desc_table:
  - MAX_LAYERS × layer_desc_t register file.
  - One write port, one combinational read port by index.
  - Synchronous active-low clear.
- All FSM logic lives in layer_sequencer.

Test Plan:
- 3-layer chain:
  - Stimulus: entries {0x000,0x100,0x200},{0x200,0x120,0x300},{0x300,0x140,0x020}; num_layers=3; model lyr_done 40 cycles after each lyr_start.
  - Expect: exactly 3 lyr_start pulses; bases match each entry in order; cur_layer 0,1,2; single done pulse; busy low the cycle after done.
- Stall on busy: lyr_busy held 1 for 10 cycles after run_start → lyr_start first appears the cycle after lyr_busy falls.
- Illegal count:
  - num_layers=0 → error=1, no lyr_start, busy stays 0.
  - Next run with num_layers=1 → error clears, one layer runs.
- Abort: assert abort in WAIT of layer 1 of 4 → busy=0 next cycle, no done, no further lyr_start; a following run restarts at cur_layer=0.
- Ignored inputs while busy:
  - cfg_wr_en to entry 1 during layer 0 → layer 1 still uses the original bases.
  - Second run_start mid-chain → ignored.
- Watchdog (LAYER_TIMEOUT_EN, TIMEOUT_CYCLES=64): lyr_done never arrives → error=1 after 64 WAIT cycles, return to IDLE, done never pulses.
